div_unit: RTL and testbench
===========================

// Module: div_unit
// PURPOSE
//  Iterative radix-2 divider for DIV/DIVU in the EX stage, downstream of the main decoder.
//  Takes rs/rt when the decoder flags a divide.
//  Produces {HI=remainder, LO=quotient} for the HI/LO register write (hilowrite path).
//  Holds the pipeline via busy_o while iterating.
// PARAMETERS
//  WIDTH     32   operand width; result is 2*WIDTH
//  CNT_W     6    iteration counter width; must hold WIDTH
// PORTS
//  clk       in   1        rising-edge clock
//  rst       in   1        asynchronous, active-low reset
//  start_i   in   1        divide request from EX (decoded DIV/DIVU, not annulled)
//  signed_i  in   1        1=DIV (two's complement), 0=DIVU
//  opa_i     in   WIDTH    dividend (rs)
//  opb_i     in   WIDTH    divisor (rt)
//  annul_i   in   1        flush/exception: abandon current divide
//  busy_o    out  1        stall request to hazard unit
//  ready_o   out  1        result valid, one-cycle pulse
//  result_o  out  2*WIDTH  {remainder, quotient}; feeds HI/LO write
// BEHAVIOUR
//  - Reset (rst=0, async): state=IDLE, cnt=0, result_o=0, ready_o=0, busy_o=0.
//  - FSM: IDLE, DIVZERO, ON, END. Encodings live in defines2.vh.
//  - IDLE: on start_i & ~annul_i, capture operands and signs at that edge.
//    If opb_i==0, go to DIVZERO; otherwise go to ON with cnt=0.
//    In DIVU or for positive operands, |x| = x; negative signed operands are negated.
//  - ON: one restoring step per cycle on the {rem,quot} shift register:
//    shift left 1; trial = rem_hi - |b| (WIDTH+1 bits);
//    if non-negative, rem_hi = trial and set quot bit 0.
//    cnt++; after the WIDTH-th step, go to END.
//  - DIVZERO: one cycle, then END with result 0 (both HI and LO = 0).
//  - Entering END: sign fixup registered into result_o.
//    Quotient is negated iff signed_i and the operand signs differ.
//    Remainder takes the dividend's sign.
//    0x80000000 / 0xFFFFFFFF (signed) gives LO=0x80000000, HI=0 (wraps, no trap).
//  - END: ready_o=1 for exactly this cycle, then IDLE. start_i is ignored in END.
//  - Latency: start sampled in cycle T; ON occupies T+1..T+WIDTH; END/ready_o at T+WIDTH+1 (T+33).
//    Divide-by-zero: ready_o at T+2.
//  - busy_o = (IDLE & start_i & ~annul_i) | ON | DIVZERO.
//    busy_o is low in END, so EX advances in the same cycle the result is written.
//  - start_i while ON/DIVZERO is ignored; operands are not re-sampled.
//  - annul_i in ON/DIVZERO: go to IDLE next edge, no ready_o, result_o unchanged.
//    annul_i in END: ready_o is suppressed that cycle.
//  - result_o holds its value until the next END; it is never cleared except by reset.
//  - Reset mid-divide: immediate return to IDLE, no ready_o.
// STRUCTURE
//  - defines2.vh: DivFree/DivByZero/DivOn/DivEnd state codes, DivResultReady/NotReady, DIV/DIVU functs.
//  - Single module. Subtract/shift step is inline combinational logic; no sub-module.
//  - Negation helper is a local function; no multiplier or DSP inference.
// TESTING
//  1. DIVU 100/7, start at T -> busy_o 1 in T..T+32; ready_o=1 at T+33; result_o={32'd2,32'd14}.
//  2. DIV -7/2 (0xFFFFFFF9/2) -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIV 7/-2 -> LO=0xFFFFFFFD, HI=1.
//  3. DIVU 0xFFFFFFFF/1 -> LO=0xFFFFFFFF, HI=0.
//     DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
//  4. DIV 5/0 -> DIVZERO at T+1; ready_o at T+2; result_o=0; busy_o low at T+2.
//  5. Annul/reset: annul_i at T+10 -> no ready_o; busy_o=0 at T+11.
//     New DIVU 9/3 at T+11 -> ready_o at T+44, {0,3}.
//     rst=0 at T+5 -> all outputs 0 immediately.
//  6. Random signed/unsigned operand sweep (1000 vectors).
//     Compare against the reference model Q=a/b, R=a%b (truncating).
//     Check that start_i pulses during ON do not perturb the result.

Source files
------------

// File: rtl/div_unit_pkg.sv
// Shared definitions for the iterative radix-2 divider: FSM state codes and
// result-ready levels used by div_unit and its bench.
package div_unit_pkg;

  typedef enum logic [1:0] {
    DIV_FREE     = 2'b00,
    DIV_BY_ZERO  = 2'b01,
    DIV_ON       = 2'b10,
    DIV_END      = 2'b11
  } div_state_e;

  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;

endpackage

// File: rtl/div_unit.sv
// Iterative restoring divider for DIV/DIVU: one quotient bit per cycle,
// {HI=remainder, LO=quotient} registered on entry to DIV_END.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               signed_i,
  input  logic [WIDTH-1:0]   opa_i,
  input  logic [WIDTH-1:0]   opb_i,
  input  logic               annul_i,
  output logic               busy_o,
  output logic               ready_o,
  output logic [2*WIDTH-1:0] result_o,
  output div_state_e         state_o
);

  // Handshake: start_i is taken only in DIV_FREE when annul_i is low; busy_o
  // stalls EX from that cycle until the result cycle, and ready_o is a single
  // cycle pulse in DIV_END (dropped if annul_i is high in that cycle).

  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  div_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   quot_q, quot_d;
  logic [WIDTH-1:0]   absb_q, absb_d;
  logic               neg_quot_q, neg_quot_d;
  logic               neg_rem_q, neg_rem_d;
  logic [2*WIDTH-1:0] result_q, result_d;

  logic [WIDTH:0]     trial;
  logic               step_ok;
  logic [WIDTH-1:0]   step_rem;
  logic [WIDTH-1:0]   step_quot;
  logic [WIDTH-1:0]   fix_quot;
  logic [WIDTH-1:0]   fix_rem;

  function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] x);
    return ~x + WIDTH'(1);
  endfunction

  function automatic logic [WIDTH-1:0] magnitude(input logic sgn,
                                                 input logic [WIDTH-1:0] x);
    return (sgn && x[WIDTH-1]) ? negate(x) : x;
  endfunction

  // Remainder is always below |b|, so a failed trial never loses a set bit
  // when the partial remainder is shifted back into WIDTH bits.
  always_comb begin
    trial     = {rem_q, quot_q[WIDTH-1]} - {1'b0, absb_q};
    step_ok   = ~trial[WIDTH];
    step_rem  = step_ok ? trial[WIDTH-1:0] : {rem_q[WIDTH-2:0], quot_q[WIDTH-1]};
    step_quot = {quot_q[WIDTH-2:0], step_ok};
    fix_quot  = neg_quot_q ? negate(step_quot) : step_quot;
    fix_rem   = neg_rem_q ? negate(step_rem) : step_rem;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rem_d      = rem_q;
    quot_d     = quot_q;
    absb_d     = absb_q;
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    result_d   = result_q;
    unique case (state_q)
      DIV_FREE: begin
        if (start_i && !annul_i) begin
          neg_quot_d = signed_i & (opa_i[WIDTH-1] ^ opb_i[WIDTH-1]);
          neg_rem_d  = signed_i & opa_i[WIDTH-1];
          rem_d      = '0;
          quot_d     = magnitude(signed_i, opa_i);
          absb_d     = magnitude(signed_i, opb_i);
          cnt_d      = '0;
          state_d    = (opb_i == '0) ? DIV_BY_ZERO : DIV_ON;
        end
      end
      DIV_BY_ZERO: begin
        if (annul_i) begin
          state_d = DIV_FREE;
        end else begin
          state_d  = DIV_END;
          result_d = '0;
        end
      end
      DIV_ON: begin
        if (annul_i) begin
          state_d = DIV_FREE;
        end else begin
          rem_d  = step_rem;
          quot_d = step_quot;
          cnt_d  = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_STEP) begin
            state_d  = DIV_END;
            result_d = {fix_rem, fix_quot};
          end
        end
      end
      DIV_END: begin
        state_d = DIV_FREE;
      end
      default: state_d = DIV_FREE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= DIV_FREE;
      cnt_q      <= '0;
      rem_q      <= '0;
      quot_q     <= '0;
      absb_q     <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      result_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rem_q      <= rem_d;
      quot_q     <= quot_d;
      absb_q     <= absb_d;
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
      result_q   <= result_d;
    end
  end

  assign busy_o   = ((state_q == DIV_FREE) && start_i && !annul_i) ||
                    (state_q == DIV_ON) || (state_q == DIV_BY_ZERO);
  assign ready_o  = ((state_q == DIV_END) && !annul_i) ? DIV_RESULT_READY
                                                        : DIV_RESULT_NOT_READY;
  assign result_o = result_q;
  assign state_o  = state_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed and randomized checks of div_unit against hand-computed vectors
// and a truncating-division reference.
module tb_div_unit;
  import div_unit_pkg::*;

  logic        clk;
  logic        rst;
  logic        start_i;
  logic        signed_i;
  logic [31:0] opa_i;
  logic [31:0] opb_i;
  logic        annul_i;
  logic        busy_o;
  logic        ready_o;
  logic [63:0] result_o;
  div_state_e  state_o;

  int checks = 0;
  int errors = 0;

  div_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk      (clk),
    .rst      (rst),
    .start_i  (start_i),
    .signed_i (signed_i),
    .opa_i    (opa_i),
    .opb_i    (opb_i),
    .annul_i  (annul_i),
    .busy_o   (busy_o),
    .ready_o  (ready_o),
    .result_o (result_o),
    .state_o  (state_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  // Presents a request for one cycle; returns just after the capturing edge.
  task automatic start_op(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start_i  = 1'b1;
    signed_i = sgn;
    opa_i    = a;
    opb_i    = b;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    opa_i   = $urandom;
    opb_i   = $urandom;
  endtask

  // Counts cycles after the capturing edge until ready_o; lat = 33 means T+33.
  // A start pulse with junk operands is injected at cycle inject_at (0 = none).
  task automatic wait_ready(input int inject_at, output int lat);
    lat = 1;
    @(negedge clk);
    while (!ready_o && lat < 40) begin
      if (lat == inject_at) begin
        start_i  = 1'b1;
        signed_i = ~signed_i;
        opa_i    = $urandom;
        opb_i    = $urandom;
      end
      @(negedge clk);
      start_i = 1'b0;
      lat++;
    end
  endtask

  function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] a,
                                          input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) return 64'd0;
    if (!sgn) return {a % b, a / b};
    sa = $signed(a);
    sb = $signed(b);
    q  = sa / sb;
    r  = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset;
    rst = 1'b0; start_i = 1'b0; signed_i = 1'b0; opa_i = '0; opb_i = '0; annul_i = 1'b0;
    #2;
    checks++;
    if (busy_o !== 1'b0 || ready_o !== 1'b0 || result_o !== 64'd0 || state_o !== DIV_FREE) begin
      errors++;
      $display("FAIL reset: busy=%b ready=%b result=%h state=%0d, required 0/0/0/FREE",
               busy_o, ready_o, result_o, state_o);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_divu_basic;
    int lat;
    int busy_bad;
    busy_bad = 0;
    @(negedge clk);
    start_i = 1'b1; signed_i = 1'b0; opa_i = 32'd100; opb_i = 32'd7;
    #1;
    checks++;
    if (busy_o !== 1'b1) begin
      errors++;
      $display("FAIL divu_busy_T: busy=%b required 1", busy_o);
    end
    @(posedge clk);
    #1;
    start_i = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!ready_o && lat < 40) begin
      if (busy_o !== 1'b1) busy_bad++;
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat !== 33) begin
      errors++;
      $display("FAIL divu_latency: ready at T+%0d required T+33", lat);
    end
    checks++;
    if (busy_bad !== 0 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL divu_busy_window: low cycles=%0d busy_at_ready=%b required 0/0", busy_bad, busy_o);
    end
    checks++;
    if (result_o !== {32'd2, 32'd14} || state_o !== DIV_END) begin
      errors++;
      $display("FAIL divu_100_7: result=%h state=%0d required %h END",
               result_o, state_o, {32'd2, 32'd14});
    end
    @(negedge clk);
    checks++;
    if (ready_o !== 1'b0 || state_o !== DIV_FREE || result_o !== {32'd2, 32'd14}) begin
      errors++;
      $display("FAIL ready_pulse: ready=%b state=%0d result=%h required 0 FREE held",
               ready_o, state_o, result_o);
    end
  endtask

  task automatic test_vectors;
    logic        sgn_t [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [31:0] a_t   [5] = '{32'hFFFF_FFF9, 32'd7, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFF9};
    logic [31:0] b_t   [5] = '{32'd2, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    logic [63:0] exp_t [5] = '{{32'hFFFF_FFFF, 32'hFFFF_FFFD}, {32'd1, 32'hFFFF_FFFD},
                               {32'd0, 32'hFFFF_FFFF}, {32'd0, 32'h8000_0000},
                               {32'hFFFF_FFFF, 32'd3}};
    int lat;
    for (int i = 0; i < 5; i++) begin
      start_op(sgn_t[i], a_t[i], b_t[i]);
      wait_ready(0, lat);
      checks++;
      if (result_o !== exp_t[i] || lat !== 33) begin
        errors++;
        $display("FAIL vector_%0d: result=%h lat=%0d required %h lat=33",
                 i, result_o, lat, exp_t[i]);
      end
    end
  endtask

  task automatic test_divzero;
    int lat;
    start_op(1'b1, 32'd5, 32'd0);
    #1;
    checks++;
    if (state_o !== DIV_BY_ZERO || busy_o !== 1'b1) begin
      errors++;
      $display("FAIL divzero_state: state=%0d busy=%b required BY_ZERO 1", state_o, busy_o);
    end
    wait_ready(0, lat);
    checks++;
    if (lat !== 2 || result_o !== 64'd0 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL divzero: lat=%0d result=%h busy=%b required 2 0 0", lat, result_o, busy_o);
    end
  endtask

  task automatic test_annul;
    logic [63:0] prev;
    int lat;
    prev = result_o;
    start_op(1'b0, 32'd1000, 32'd3);
    repeat (10) @(negedge clk);
    annul_i = 1'b1;
    @(negedge clk);
    annul_i = 1'b0;
    checks++;
    if (busy_o !== 1'b0 || ready_o !== 1'b0 || state_o !== DIV_FREE || result_o !== prev) begin
      errors++;
      $display("FAIL annul_on: busy=%b ready=%b state=%0d result=%h required 0 0 FREE %h",
               busy_o, ready_o, state_o, result_o, prev);
    end
    start_i = 1'b1; signed_i = 1'b0; opa_i = 32'd9; opb_i = 32'd3;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    wait_ready(0, lat);
    checks++;
    if (lat !== 33 || result_o !== {32'd0, 32'd3}) begin
      errors++;
      $display("FAIL annul_restart: lat=%0d result=%h required 33 %h", lat, result_o, {32'd0, 32'd3});
    end
  endtask

  task automatic test_annul_end;
    start_op(1'b0, 32'd50, 32'd8);
    repeat (32) @(negedge clk);
    @(posedge clk);
    #1;
    annul_i = 1'b1;
    #1;
    checks++;
    if (ready_o !== 1'b0 || state_o !== DIV_END || result_o !== {32'd2, 32'd6}) begin
      errors++;
      $display("FAIL annul_end: ready=%b state=%0d result=%h required 0 END %h",
               ready_o, state_o, result_o, {32'd2, 32'd6});
    end
    @(posedge clk);
    #1;
    annul_i = 1'b0;
    checks++;
    if (state_o !== DIV_FREE) begin
      errors++;
      $display("FAIL annul_end_exit: state=%0d required FREE", state_o);
    end
  endtask

  task automatic test_reset_mid;
    start_op(1'b1, 32'hFFFF_0000, 32'd17);
    repeat (5) @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (busy_o !== 1'b0 || ready_o !== 1'b0 || result_o !== 64'd0 || state_o !== DIV_FREE) begin
      errors++;
      $display("FAIL reset_mid: busy=%b ready=%b result=%h state=%0d required 0 0 0 FREE",
               busy_o, ready_o, result_o, state_o);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_random;
    logic [63:0] exp_q[$];
    logic [63:0] expv;
    logic [31:0] a, b;
    logic        sgn;
    int lat, sel;
    for (int i = 0; i < 1000; i++) begin
      sgn = 1'($urandom_range(0, 1));
      a   = $urandom;
      sel = $urandom_range(0, 9);
      if (sel == 0)      b = 32'd0;
      else if (sel < 4)  b = $urandom_range(1, 15);
      else if (sel < 6)  b = -32'($urandom_range(1, 15));
      else               b = $urandom;
      if (sel == 9) a = $urandom_range(0, 100);
      exp_q.push_back(ref_div(sgn, a, b));
      start_op(sgn, a, b);
      wait_ready((i % 2 == 1) ? 7 : 0, lat);
      expv = exp_q.pop_front();
      checks++;
      if (result_o !== expv || lat !== ((b == 32'd0) ? 2 : 33)) begin
        errors++;
        $display("FAIL random_%0d: sgn=%b a=%h b=%h result=%h lat=%0d required %h",
                 i, sgn, a, b, result_o, lat, expv);
      end
    end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    test_reset();
    test_divu_basic();
    test_vectors();
    test_divzero();
    test_annul();
    test_annul_end();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
